vga_sync_gen: RTL and testbench
===============================

# vga_sync_gen

Timing source for the VGA display path: divides the 100 MHz system clock to a 25 MHz pixel tick and runs horizontal and vertical counters for 640x480 @ 60 Hz. It drives `hsync`/`vsync` to the connector and supplies `video_on`, `x`, `y` to the pixel generation stage. `x`/`y` run through the blanking intervals, so downstream logic can decode events there (for example the refresh tick at `y == 481`, `x == 0`).

## Interface
- `H_DISPLAY`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: hsync pulse width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_DISPLAY`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vsync pulse width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `clk`  in  1  100 MHz system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `hsync`  out  1  horizontal sync, active low, registered.
- `vsync`  out  1  vertical sync, active low, registered.
- `video_on`  out  1  high when `x < H_DISPLAY` and `y < V_DISPLAY`.
- `p_tick`  out  1  one-`clk` pixel strobe, asserted every 4th cycle.
- `x`  out  10  horizontal count, range 0..799.
- `y`  out  10  vertical count, range 0..524.
- `frame_tick`  out  1  one-`clk` end-of-frame pulse. Present only with `VGA_SYNC_FRAME_TICK_EN`.

## Operation
- Derived totals: H_TOTAL = 800 and V_TOTAL = 525, each the sum of its four parameters.
- Pixel divider:
  - 2-bit `tick_cnt` increments every `clk` and wraps 3 -> 0.
  - `p_tick` = (`tick_cnt` == 3), decoded from the register.
- Horizontal counter:
  - Advances only on `clk` edges where `p_tick` = 1.
  - At H_TOTAL-1 it wraps to 0.
- Vertical counter:
  - Advances only on a `p_tick` edge where the horizontal count is at H_TOTAL-1.
  - At V_TOTAL-1 it wraps to 0.
- `x` and `y` are the counter registers themselves. Neither ever exceeds H_TOTAL-1 / V_TOTAL-1.
- `hsync` and `vsync` are registered from the next-state counter values, so they stay cycle-aligned with `x`/`y`:
  - `hsync` = 0 for `x` in 656..751.
  - `vsync` = 0 for `y` in 490..491.
- `video_on` is a combinational decode of the counter registers.
- Values in reset:
  - `tick_cnt`, `x`, `y`: 0.
  - `p_tick`: 0.
  - `hsync`, `vsync`: 1.
  - `video_on`: 1, since it decodes `x` = 0, `y` = 0.
  - `frame_tick`: 0.
- Reset asserted mid-frame: all of the above take their reset values immediately. The first line restarts at `x` = 0, `y` = 0 once reset is released. No partial-line recovery.

## Timing
- After reset release, the first `p_tick` occurs on the 4th `clk` edge.
- Each `x` value is held for exactly 4 `clk` cycles.
- Line period: 3,200 `clk` cycles.
- Frame period: 1,680,000 `clk` cycles, which is 59.52 Hz at 100 MHz.
- hsync low: 384 `clk` cycles per line. vsync low: 6,400 `clk` cycles per frame.
- `x`, `y`, `hsync`, `vsync` and `video_on` all change on the same `clk` edge.
- Latency from counter state to pin: 0 cycles.

## Configuration
- `VGA_SYNC_FRAME_TICK_EN` defined:
  - The `frame_tick` port exists.
  - It pulses high for exactly one `clk`, in the cycle where `p_tick` = 1, `x` = 799 and `y` = 524.
  - That is one pulse per frame; it is 0 during reset.
- Macro undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package `vga_timing_pkg` holds:
  - The 640x480@60 porch/sync constants.
  - H_TOTAL and V_TOTAL.
  - The sync polarity constant (active low).
  - The 10-bit coordinate width.
- Parameter defaults are taken from the package.
- One sub-module, `pixel_tick_div`: owns `tick_cnt`, takes `clk`/`reset`, and outputs `p_tick`.

## Test plan
- Reset held 10 cycles, then released:
  - During reset: `x` = 0, `y` = 0, `hsync` = `vsync` = 1, `p_tick` = 0.
  - After release: first `p_tick` on cycle 4, then `p_tick` asserted every 4 cycles thereafter.
- Run one line:
  - `x` steps 0..799, each value held 4 cycles.
  - `hsync` falls when `x` becomes 656 and rises when `x` becomes 752 (low for 384 cycles).
  - `video_on` falls when `x` becomes 640.
- Run one full frame:
  - `y` advances only at the `x` 799 -> 0 wrap.
  - `vsync` is low exactly while `y` is 490..491.
  - `y` wraps 524 -> 0 after 1,680,000 cycles.
- Check the refresh decode: (`y` == 481 && `x` == 0) is true for exactly 4 consecutive `clk` cycles per frame.
- Assert reset at `x` = 700, `y` = 300 for 3 cycles:
  - All outputs take their reset values asynchronously.
  - The next frame runs the full 1,680,000 cycles from release.
- With `VGA_SYNC_FRAME_TICK_EN`: over 3 frames, `frame_tick` fires exactly 3 times, 1,680,000 cycles apart, each coincident with `p_tick` at `x` = 799, `y` = 524.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480@60 timing constants, sync polarity and coordinate width.
package vga_timing_pkg;
    localparam int VGA_H_DISPLAY = 640;
    localparam int VGA_H_FP      = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BP      = 48;
    localparam int VGA_V_DISPLAY = 480;
    localparam int VGA_V_FP      = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BP      = 33;
    localparam int VGA_H_TOTAL   = VGA_H_DISPLAY + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL   = VGA_V_DISPLAY + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam logic SYNC_ACTIVE = 1'b0;
    localparam int COORD_W       = 10;
endpackage

// File: rtl/vga_sync_gen_pixel_tick_div.sv
// pixel_tick_div: divides clk by 4 into a one-cycle pixel strobe.
module pixel_tick_div (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);
    logic [1:0] tick_cnt;
    always_ff @(posedge clk or negedge reset)
        if (!reset) tick_cnt <= '0;
        else tick_cnt <= tick_cnt + 2'd1;
    assign p_tick = tick_cnt == 2'd3;
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 VGA timing generator (hsync/vsync, video_on, x/y).
// Define VGA_SYNC_FRAME_TICK_EN to add the frame_tick end-of-frame strobe.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY = VGA_H_DISPLAY,
    parameter int H_FP      = VGA_H_FP,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BP      = VGA_H_BP,
    parameter int V_DISPLAY = VGA_V_DISPLAY,
    parameter int V_FP      = VGA_V_FP,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BP      = VGA_V_BP
) (
    input  logic               clk,
    input  logic               reset,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               p_tick,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y
`ifdef VGA_SYNC_FRAME_TICK_EN
    ,
    output logic               frame_tick
`endif
);
    localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VIS  = COORD_W'(H_DISPLAY);
    localparam logic [COORD_W-1:0] V_VIS  = COORD_W'(V_DISPLAY);
    localparam logic [COORD_W-1:0] HS_BEG = COORD_W'(H_DISPLAY + H_FP);
    localparam logic [COORD_W-1:0] HS_END = COORD_W'(H_DISPLAY + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_BEG = COORD_W'(V_DISPLAY + V_FP);
    localparam logic [COORD_W-1:0] VS_END = COORD_W'(V_DISPLAY + V_FP + V_SYNC);
    logic               h_end;
    logic [COORD_W-1:0] x_next, y_next;
    pixel_tick_div u_div (.clk(clk), .reset(reset), .p_tick(p_tick));
    always_comb begin
        h_end  = p_tick && x == H_LAST;
        x_next = h_end ? '0 : p_tick ? x + COORD_W'(1) : x;
        y_next = h_end ? (y == V_LAST ? '0 : y + COORD_W'(1)) : y;
    end
    // Syncs decode the next-state counters so they change on the same edge as x/y.
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            x     <= '0;
            y     <= '0;
            hsync <= ~SYNC_ACTIVE;
            vsync <= ~SYNC_ACTIVE;
        end else begin
            x     <= x_next;
            y     <= y_next;
            hsync <= (x_next >= HS_BEG && x_next < HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync <= (y_next >= VS_BEG && y_next < VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        end
    assign video_on = x < H_VIS && y < V_VIS;
`ifdef VGA_SYNC_FRAME_TICK_EN
    assign frame_tick = p_tick && x == H_LAST && y == V_LAST;
`endif
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: checks a full-size and a shrunken-timing vga_sync_gen against an arithmetic model.
// Define VGA_SYNC_FRAME_TICK_EN to also check frame_tick.
module tb_vga_sync_gen;
    typedef struct {
        logic [9:0] x, y;
        logic hs, vs, von, pt, ft;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a = 1'b0, rst_b = 1'b0;
    logic hs_a, vs_a, von_a, pt_a, hs_b, vs_b, von_b, pt_b;
    logic [9:0] xa, ya, xb, yb;
    logic ft_a, ft_b;
    longint na = 0, nb = 0;
    int vectors = 0, miscompares = 0;
    bit ph1 = 1'b1;
    int hlow = 0, refresh = 0, ftc = 0;
    longint ft_first = -1, ft_last = -1;

    always #5 clk = ~clk;

    vga_sync_gen dut_a (
        .clk(clk), .reset(rst_a), .hsync(hs_a), .vsync(vs_a), .video_on(von_a),
        .p_tick(pt_a), .x(xa), .y(ya)
`ifdef VGA_SYNC_FRAME_TICK_EN
        , .frame_tick(ft_a)
`endif
    );

    vga_sync_gen #(
        .H_DISPLAY(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_DISPLAY(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dut_b (
        .clk(clk), .reset(rst_b), .hsync(hs_b), .vsync(vs_b), .video_on(von_b),
        .p_tick(pt_b), .x(xb), .y(yb)
`ifdef VGA_SYNC_FRAME_TICK_EN
        , .frame_tick(ft_b)
`endif
    );

`ifndef VGA_SYNC_FRAME_TICK_EN
    assign ft_a = 1'b0;
    assign ft_b = 1'b0;
`endif

    // Clock edges seen since the last reset release, per instance.
    always @(posedge clk or negedge rst_a) if (!rst_a) na <= 0; else na <= na + 1;
    always @(posedge clk or negedge rst_b) if (!rst_b) nb <= 0; else nb <= nb + 1;

    function automatic exp_t model(input longint n, input int hd, hfp, sw, hbp, vd, vfp, vsw, vbp);
        exp_t e;
        longint ht = hd + hfp + sw + hbp, vt = vd + vfp + vsw + vbp;
        longint pix = n / 4, xi = pix % ht, yi = (pix / ht) % vt;
        e.x   = 10'(xi);
        e.y   = 10'(yi);
        e.pt  = (n % 4) == 3;
        e.hs  = !(xi >= hd + hfp && xi < hd + hfp + sw);
        e.vs  = !(yi >= vd + vfp && yi < vd + vfp + vsw);
        e.von = xi < hd && yi < vd;
        e.ft  = e.pt && xi == ht - 1 && yi == vt - 1;
        return e;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (time %0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t ea, eb;
        ea = model(na, 640, 16, 96, 48, 480, 10, 2, 33);
        eb = model(nb, 16, 4, 6, 4, 12, 2, 2, 3);
        chk("a_x", xa, ea.x);  chk("a_y", ya, ea.y);
        chk("a_hsync", hs_a, ea.hs); chk("a_vsync", vs_a, ea.vs);
        chk("a_video_on", von_a, ea.von); chk("a_p_tick", pt_a, ea.pt);
        chk("b_x", xb, eb.x);  chk("b_y", yb, eb.y);
        chk("b_hsync", hs_b, eb.hs); chk("b_vsync", vs_b, eb.vs);
        chk("b_video_on", von_b, eb.von); chk("b_p_tick", pt_b, eb.pt);
`ifdef VGA_SYNC_FRAME_TICK_EN
        chk("a_frame_tick", ft_a, ea.ft);
        chk("b_frame_tick", ft_b, eb.ft);
`endif
        if (rst_a && na < 3200 && !hs_a) hlow++;
        if (ph1 && rst_b && yb == 10'd13 && xb == 10'd0) refresh++;
        if (ph1 && rst_b && ft_b) begin
            ftc++;
            if (ft_first < 0) ft_first = nb;
            ft_last = nb;
        end
    end

    task automatic wait_a(input longint t);
        for (int i = 0; i < 20000 && na != t; i++) @(negedge clk);
        chk("wait_a", na, t);
    endtask

    task automatic wait_b(input longint t);
        for (int i = 0; i < 20000 && nb != t; i++) @(negedge clk);
        chk("wait_b", nb, t);
    endtask

    task automatic chk_reset_b();
        #1;
        chk("b_async_x", xb, 0); chk("b_async_y", yb, 0);
        chk("b_async_hsync", hs_b, 1); chk("b_async_vsync", vs_b, 1);
        chk("b_async_p_tick", pt_b, 0); chk("b_async_video_on", von_b, 1);
        chk("b_async_frame_tick", ft_b, 0);
    endtask

    initial begin
        repeat (10) @(negedge clk);
        chk("rst_x", xa, 0); chk("rst_hsync", hs_a, 1); chk("rst_p_tick", pt_a, 0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        wait_a(2);    chk("first_ptick_pre", pt_a, 0);
        wait_a(3);    chk("first_ptick", pt_a, 1);
        wait_a(7);    chk("second_ptick", pt_a, 1);
        wait_b(2279); chk("b_last_x", xb, 29); chk("b_last_y", yb, 18);
        wait_b(2280); chk("b_wrap_x", xb, 0); chk("b_wrap_y", yb, 0);
        wait_a(2559); chk("von_before", von_a, 1);
        wait_a(2560); chk("von_fall", von_a, 0); chk("x_640", xa, 640);
        wait_a(2623); chk("hs_before", hs_a, 1);
        wait_a(2624); chk("hs_fall", hs_a, 0); chk("x_656", xa, 656);
        wait_a(3007); chk("hs_last_low", hs_a, 0);
        wait_a(3008); chk("hs_rise", hs_a, 1); chk("x_752", xa, 752);
        wait_a(3200); chk("line_wrap_x", xa, 0); chk("line_wrap_y", ya, 1);
        chk("hsync_low_cycles", hlow, 384);
        wait_b(3 * 2280 + 10);
        ph1 = 1'b0;
        chk("refresh_cycles_3_frames", refresh, 12);
`ifdef VGA_SYNC_FRAME_TICK_EN
        chk("frame_tick_count", ftc, 3);
        chk("frame_tick_first", ft_first, 2279);
        chk("frame_tick_span", ft_last - ft_first, 2 * 2280);
`endif
        for (int i = 0; i < 20000 && !(xa == 10'd700 && ya == 10'd2); i++) @(negedge clk);
        chk("reach_x700", xa, 700);
        rst_a = 1'b0;
        #1;
        chk("a_async_x", xa, 0); chk("a_async_y", ya, 0);
        chk("a_async_hsync", hs_a, 1); chk("a_async_vsync", vs_a, 1);
        chk("a_async_p_tick", pt_a, 0); chk("a_async_video_on", von_a, 1);
        repeat (3) @(negedge clk);
        rst_a = 1'b1;
        for (int k = 0; k < 5; k++) begin
            repeat ($urandom_range(1, 3000)) @(negedge clk);
            rst_b = 1'b0;
            chk_reset_b();
            repeat ($urandom_range(1, 4)) @(negedge clk);
            rst_b = 1'b1;
        end
        wait_a(na + 10 < 3200 ? 3200 : na + 10);
        chk("a_restart_line", ya >= 1, 1);
        wait_b(nb + 2290);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
